// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv_pkg
//  Description : Shared opcodes, ALU operation codes and the control bundle
//                for the RV32I-subset single-cycle core.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv_pkg;

    localparam logic [6:0] c_OP_R    = 7'b0110011;
    localparam logic [6:0] c_OP_I    = 7'b0010011;
    localparam logic [6:0] c_OP_LW   = 7'b0000011;
    localparam logic [6:0] c_OP_SW   = 7'b0100011;
    localparam logic [6:0] c_OP_BEQ  = 7'b1100011;
    localparam logic [6:0] c_OP_JAL  = 7'b1101111;
    localparam logic [6:0] c_OP_JALR = 7'b1100111;

    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b001;
    localparam logic [2:0] c_ALU_AND = 3'b010;
    localparam logic [2:0] c_ALU_OR  = 3'b011;
    localparam logic [2:0] c_ALU_XOR = 3'b100;
    localparam logic [2:0] c_ALU_SLT = 3'b101;
    localparam logic [2:0] c_ALU_SLL = 3'b110;
    localparam logic [2:0] c_ALU_SRL = 3'b111;

    // Field order (MSB first) is relied on when the bundle is viewed as a flat vector.
    typedef struct packed {
        logic       br;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic       pc_to_reg;
        logic       alu_to_pc;
        logic [2:0] alu_op;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/single_cycle_processor_if.sv
`default_nettype none
// ============================================================================
//  Module      : single_cycle_processor_if
//  Description : Instruction fetch and debug register-read bus of the core.
//                slave = core side, master = IMEM / debug host side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface single_cycle_processor_if;
    logic [31:0] ins;
    logic [31:0] pc;
    logic [4:0]  dbg_reg_addr;
    logic [31:0] dbg_reg_data;

    modport master (output ins, output dbg_reg_addr, input pc, input dbg_reg_data);
    modport slave  (input ins, input dbg_reg_addr, output pc, output dbg_reg_data);
endinterface
`default_nettype wire

// File: rtl/rv_control.sv
`default_nettype none
// ============================================================================
//  Module      : rv_control
//  Description : Main control decode from opcode/funct3/funct7.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv_control
    import rv_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output ctrl_t      ctrl
);

    // Decode; unknown opcodes leave every control low so the core just steps pc.
    always_comb begin
        ctrl = '0;
        unique case (opcode)
            c_OP_R: begin
                ctrl.reg_write = 1'b1;
                case (funct3)
                    3'b000:  ctrl.alu_op = (funct7 == 7'b0100000) ? c_ALU_SUB : c_ALU_ADD;
                    3'b111:  ctrl.alu_op = c_ALU_AND;
                    3'b110:  ctrl.alu_op = c_ALU_OR;
                    3'b100:  ctrl.alu_op = c_ALU_XOR;
                    3'b010:  ctrl.alu_op = c_ALU_SLT;
                    3'b001:  ctrl.alu_op = c_ALU_SLL;
                    3'b101:  ctrl.alu_op = c_ALU_SRL;
                    default: ctrl.alu_op = c_ALU_ADD;
                endcase
            end
            c_OP_I: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            c_OP_LW: begin
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            c_OP_SW: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            c_OP_BEQ: begin
                ctrl.br     = 1'b1;
                ctrl.alu_op = c_ALU_SUB;
            end
            c_OP_JAL: begin
                ctrl.reg_write = 1'b1;
                ctrl.pc_to_reg = 1'b1;
            end
            c_OP_JALR: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.pc_to_reg = 1'b1;
                ctrl.alu_to_pc = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rv_imm_gen.sv
`default_nettype none
// ============================================================================
//  Module      : rv_imm_gen
//  Description : Sign-extended immediate for I/S/B/J formats; zero otherwise.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv_imm_gen
    import rv_pkg::*;
(
    input  logic [31:0] ins,
    output logic [31:0] imm
);

    // Format selected purely by opcode.
    always_comb begin
        imm = '0;
        case (ins[6:0])
            c_OP_I, c_OP_LW, c_OP_JALR: imm = {{20{ins[31]}}, ins[31:20]};
            c_OP_SW:  imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            c_OP_BEQ: imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            c_OP_JAL: imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default:  imm = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/single_cycle_processor.sv
`default_nettype none
// ============================================================================
//  Module      : single_cycle_processor
//  Description : RV32I-subset single-cycle core: pc, 32x32 register file,
//                ALU, word-addressed data memory, decode and immediates.
//  Revision    : 1.0 - initial release
// ============================================================================
module single_cycle_processor
    import rv_pkg::*;
#(
    parameter int DMEM_WORDS = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    single_cycle_processor_if.slave  bus
);

    localparam int c_AW = $clog2(DMEM_WORDS);

    logic [31:0]     r_pc;
    logic [31:0]     r_regs [32];
    logic [31:0]     r_dmem [DMEM_WORDS];

    ctrl_t           w_ctrl;
    logic [31:0]     w_imm;
    logic [4:0]      w_rs1, w_rs2, w_rd;
    logic [31:0]     w_rs1_data, w_rs2_data, w_alu_b, w_alu_result;
    logic            w_zero;
    logic [31:0]     w_pc_plus4, w_next_pc, w_wb_data, w_load_data;
    logic [c_AW-1:0] w_idx;

    rv_control u_control (
        .opcode (bus.ins[6:0]),
        .funct3 (bus.ins[14:12]),
        .funct7 (bus.ins[31:25]),
        .ctrl   (w_ctrl)
    );

    rv_imm_gen u_imm_gen (
        .ins (bus.ins),
        .imm (w_imm)
    );

    assign w_rs1      = bus.ins[19:15];
    assign w_rs2      = bus.ins[24:20];
    assign w_rd       = bus.ins[11:7];
    assign w_rs1_data = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
    assign w_rs2_data = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2];
    assign w_alu_b    = w_ctrl.alu_src ? w_imm : w_rs2_data;

    // ALU; shifts use only the low five bits of operand B.
    always_comb begin
        w_alu_result = '0;
        case (w_ctrl.alu_op)
            c_ALU_ADD: w_alu_result = w_rs1_data + w_alu_b;
            c_ALU_SUB: w_alu_result = w_rs1_data - w_alu_b;
            c_ALU_AND: w_alu_result = w_rs1_data & w_alu_b;
            c_ALU_OR:  w_alu_result = w_rs1_data | w_alu_b;
            c_ALU_XOR: w_alu_result = w_rs1_data ^ w_alu_b;
            c_ALU_SLT: w_alu_result = {31'd0, $signed(w_rs1_data) < $signed(w_alu_b)};
            c_ALU_SLL: w_alu_result = w_rs1_data << w_alu_b[4:0];
            c_ALU_SRL: w_alu_result = w_rs1_data >> w_alu_b[4:0];
            default:   w_alu_result = '0;
        endcase
    end

    assign w_zero      = (w_alu_result == 32'd0);
    assign w_idx       = w_alu_result[c_AW+1:2];
    assign w_load_data = r_dmem[w_idx];
    assign w_pc_plus4  = r_pc + 32'd4;

    // Next-pc select: register jump, then pc-relative jump/branch, else sequential.
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (w_ctrl.alu_to_pc)
            w_next_pc = {w_alu_result[31:1], 1'b0};
        else if ((bus.ins[6:0] == c_OP_JAL) || (w_ctrl.br && w_zero))
            w_next_pc = r_pc + w_imm;
    end

    assign w_wb_data = w_ctrl.pc_to_reg  ? w_pc_plus4  :
                       w_ctrl.mem_to_reg ? w_load_data : w_alu_result;

    // Program counter.
    always_ff @(posedge clk) begin
        if (rst) r_pc <= '0;
        else     r_pc <= w_next_pc;
    end

    // Register file; x0 is never written and reads back as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else if (w_ctrl.reg_write && (w_rd != 5'd0)) begin
            r_regs[w_rd] <= w_wb_data;
        end
    end

    // Data memory, word stores only.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DMEM_WORDS; i++) r_dmem[i] <= '0;
        end else if (w_ctrl.mem_write) begin
            r_dmem[w_idx] <= w_rs2_data;
        end
    end

    assign bus.pc           = r_pc;
    assign bus.dbg_reg_data = (bus.dbg_reg_addr == 5'd0) ? 32'd0 : r_regs[bus.dbg_reg_addr];

endmodule
`default_nettype wire

// File: tb/tb_single_cycle_processor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_single_cycle_processor
//  Description : Directed self-checking bench for single_cycle_processor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_single_cycle_processor;
    import rv_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    logic [31:0] exp_pc;
    logic [31:0] rv;

    single_cycle_processor_if bus ();

    single_cycle_processor #(.DMEM_WORDS(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] mk(input logic br, m2r, mw, src, rw, p2r, a2p, input logic [2:0] op);
        return {br, m2r, mw, src, rw, p2r, a2p, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, 3'b000, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, rs1);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic rd_reg(input logic [4:0] idx, output logic [31:0] val);
        bus.dbg_reg_addr = idx;
        #1;
        val = bus.dbg_reg_data;
    endtask

    // Present an instruction, check its decode, then execute it on the next edge.
    task automatic step(input string tag, input logic [31:0] instr,
                        input logic [9:0] exp_ctrl, input logic [31:0] exp_imm);
        bus.ins = instr;
        #1;
        chk({tag, "_ctrl"}, {22'd0, dut.w_ctrl}, {22'd0, exp_ctrl});
        chk({tag, "_imm"}, dut.w_imm, exp_imm);
        @(posedge clk);
        #1;
    endtask

    task automatic exec(input logic [31:0] instr);
        bus.ins = instr;
        @(posedge clk);
        #1;
        exp_pc = exp_pc + 32'd4;
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] idx, input logic [31:0] expv);
        logic [31:0] v;
        rd_reg(idx, v);
        chk(tag, v, expv);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.ins = 32'd0;
        bus.dbg_reg_addr = 5'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_pc", bus.pc, 32'd0);
        chk_reg("reset_a0", 5'd10, 32'd0);

        step("add", 32'h00b00533, mk(0,0,0,0,1,0,0,3'b000), 32'd0);
        chk("add_pc", bus.pc, 32'd4);
        chk_reg("add_a0", 5'd10, 32'd0);

        step("addi", 32'h02000513, mk(0,0,0,1,1,0,0,3'b000), 32'd32);
        chk("addi_pc", bus.pc, 32'd8);
        chk_reg("addi_a0", 5'd10, 32'd32);

        step("lw", 32'h0005a503, mk(0,1,0,1,1,0,0,3'b000), 32'd0);
        chk_reg("lw_a0", 5'd10, 32'd0);

        step("sw", 32'h00a5a023, mk(0,0,1,1,0,0,0,3'b000), 32'd0);
        chk("sw_pc", bus.pc, 32'd16);

        step("beq", 32'h00b50263, mk(1,0,0,0,0,0,0,3'b001), 32'd4);
        chk("beq_pc", bus.pc, 32'd20);

        step("jal", 32'hfedff0ef, mk(0,0,0,0,1,1,0,3'b000), 32'hffffffec);
        chk("jal_pc", bus.pc, 32'd0);
        chk_reg("jal_ra", 5'd1, 32'd24);

        step("jalr", 32'h004580e7, mk(0,0,0,1,1,1,1,3'b000), 32'd4);
        chk("jalr_pc", bus.pc, 32'd4);
        chk_reg("jalr_ra", 5'd1, 32'd4);

        // ALU coverage with a negative and a small positive operand.
        exp_pc = 32'd4;
        exec(enc_i(12'hff9, 5'd0, 5'd5, 7'b0010011));
        exec(enc_i(12'd3, 5'd0, 5'd6, 7'b0010011));
        chk_reg("addi_neg", 5'd5, 32'hfffffff9);
        exec(enc_r(7'b0100000, 5'd6, 5'd5, 3'b000, 5'd7));
        exec(enc_r(7'b0000000, 5'd6, 5'd5, 3'b010, 5'd8));
        exec(enc_r(7'b0000000, 5'd6, 5'd6, 3'b001, 5'd9));
        exec(enc_r(7'b0000000, 5'd6, 5'd5, 3'b101, 5'd10));
        exec(enc_r(7'b0000000, 5'd6, 5'd5, 3'b111, 5'd11));
        exec(enc_r(7'b0000000, 5'd6, 5'd5, 3'b110, 5'd12));
        exec(enc_r(7'b0000000, 5'd6, 5'd5, 3'b100, 5'd13));
        exec(enc_r(7'b0000000, 5'd6, 5'd5, 3'b000, 5'd14));
        chk_reg("sub", 5'd7, 32'hfffffff6);
        chk_reg("slt", 5'd8, 32'd1);
        chk_reg("sll", 5'd9, 32'd24);
        chk_reg("srl", 5'd10, 32'h1fffffff);
        chk_reg("and", 5'd11, 32'd1);
        chk_reg("or", 5'd12, 32'hfffffffb);
        chk_reg("xor", 5'd13, 32'hfffffffa);
        chk_reg("add_r", 5'd14, 32'hfffffffc);

        // Store to word 2, reload through an address that wraps onto the same word.
        exec(enc_s(12'd8, 5'd5, 5'd0));
        exec(enc_i(12'd264, 5'd0, 5'd15, 7'b0000011));
        chk_reg("lw_wrap", 5'd15, 32'hfffffff9);

        exec(enc_b(13'd8, 5'd6, 5'd5));
        chk("beq_not_taken_pc", bus.pc, exp_pc);

        exec(enc_i(12'd5, 5'd0, 5'd0, 7'b0010011));
        chk_reg("x0_hardwired", 5'd0, 32'd0);
        rd_reg(5'd0, rv);
        exec(enc_i(12'd1, 5'd5, 5'd5, 7'b0010011));
        chk_reg("self_update", 5'd5, 32'hfffffffa);
        chk("seq_pc", bus.pc, exp_pc);

        // Mid-run reset held while a writing instruction is presented.
        bus.ins = enc_i(12'd1, 5'd0, 5'd1, 7'b0010011);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) begin
            rd_reg(5'(i), rv);
            chk($sformatf("midrst_x%0d", i), rv, 32'd0);
        end
        chk("midrst_pc", bus.pc, 32'd0);

        @(negedge clk);
        rst = 1'b0;
        bus.ins = 32'd0;
        #1;
        chk("nop_ctrl", {22'd0, dut.w_ctrl}, 32'd0);
        @(posedge clk);
        #1;
        chk("nop_pc", bus.pc, 32'd4);

        exp_pc = 32'd4;
        exec(enc_i(12'd8, 5'd0, 5'd15, 7'b0000011));
        chk_reg("dmem_cleared", 5'd15, 32'd0);
        chk("final_pc", bus.pc, exp_pc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
